// File: rtl/board_input_debounce.sv
// Board switch/button conditioner: 2-FF synchroniser plus counter debouncer per input,
// one-cycle edge strobes, sticky event flags and a registered interrupt request.
module board_input_debounce #(
    parameter int CLOCK_FREQUENCY = 25_000_000,
    parameter int DEBOUNCE_US     = 10_000,
    parameter int N_SW            = 16,
    parameter int N_BTN           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_SW-1:0]  sw_change_o,
    output logic [N_BTN:0]   evt_o,
    input  logic [N_BTN:0]   evt_mask_i,
    input  logic [N_BTN:0]   evt_clr_i,
    output logic             int_req_o,
    input  logic             int_fin_i
);

    // Dividing first keeps the product inside 32 bits; DEBOUNCE_CYCLES must be >= 2.
    localparam int DEBOUNCE_CYCLES = CLOCK_FREQUENCY / 1_000_000 * DEBOUNCE_US;
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES);
    localparam int N_IN            = N_SW + N_BTN;
    localparam int SETTLE_LAST     = DEBOUNCE_CYCLES + 1;
    localparam int SETTLE_W        = $clog2(SETTLE_LAST + 1);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [N_IN-1:0]     sync1_q, sync2_q;
    logic [N_IN-1:0]     stable_q, stable_d;
    logic [N_IN-1:0]     rise_q, rise_d;
    logic [N_IN-1:0]     fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [N_IN];
    logic [CNT_W-1:0]    cnt_d [N_IN];
    logic [N_BTN:0]      evt_q, evt_d;
    logic [N_BTN:0]      evt_set, evt_clr;
    logic                int_req_q;

    // Switches occupy the low bits, buttons the high bits of every per-input vector.
    always_comb begin
        // NOTE: every signal gets its default before any branch so no latch is inferred.
        state_d  = state_q;
        settle_d = settle_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
        end

        case (state_q)
            SETTLE: begin
                stable_d = sync2_q;
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_W'(SETTLE_LAST)) begin
                    state_d  = RUN;
                    settle_d = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (sync2_q[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            stable_d[i] = sync2_q[i];
                            rise_d[i]   = sync2_q[i];
                            fall_d[i]   = ~sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // A set arriving in the same cycle as a clear wins.
    assign evt_set = {|sw_change_o, btn_press_o};
    assign evt_clr = evt_clr_i | ({(N_BTN + 1){int_fin_i}} & evt_mask_i);
    assign evt_d   = (evt_q & ~evt_clr) | evt_set;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= SETTLE;
            settle_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            evt_q     <= '0;
            int_req_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            sync1_q   <= {btn_i, sw_i};
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_q     <= evt_d;
            int_req_q <= |(evt_q & evt_mask_i);
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o          = stable_q[N_SW-1:0];
    assign btn_o         = stable_q[N_IN-1:N_SW];
    assign btn_press_o   = rise_q[N_IN-1:N_SW];
    assign btn_release_o = fall_q[N_IN-1:N_SW];
    assign sw_change_o   = rise_q[N_SW-1:0] | fall_q[N_SW-1:0];
    assign evt_o         = evt_q;
    assign int_req_o     = int_req_q;

endmodule

// File: tb/tb_board_input_debounce.sv
// Self-checking bench: directed scenarios plus randomized pin activity, all scored against
// a behavioural model that decides debounced levels from a sliding window of sampled inputs.
module tb_board_input_debounce;

    localparam int D     = 16;
    localparam int N_SW  = 16;
    localparam int N_BTN = 5;
    localparam int NI    = N_SW + N_BTN;

    logic             clk;
    logic             rst;
    logic [N_SW-1:0]  sw_i;
    logic [N_BTN-1:0] btn_i;
    logic [N_SW-1:0]  sw_o;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;
    logic [N_SW-1:0]  sw_change_o;
    logic [N_BTN:0]   evt_o;
    logic [N_BTN:0]   evt_mask_i;
    logic [N_BTN:0]   evt_clr_i;
    logic             int_req_o;
    logic             int_fin_i;

    board_input_debounce #(
        .CLOCK_FREQUENCY(1_000_000),
        .DEBOUNCE_US    (16),
        .N_SW           (N_SW),
        .N_BTN          (N_BTN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_i         (sw_i),
        .btn_i        (btn_i),
        .sw_o         (sw_o),
        .btn_o        (btn_o),
        .btn_press_o  (btn_press_o),
        .btn_release_o(btn_release_o),
        .sw_change_o  (sw_change_o),
        .evt_o        (evt_o),
        .evt_mask_i   (evt_mask_i),
        .evt_clr_i    (evt_clr_i),
        .int_req_o    (int_req_o),
        .int_fin_i    (int_fin_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_SW-1:0]  sw;
        logic [N_BTN-1:0] btn;
        logic [N_BTN-1:0] press;
        logic [N_BTN-1:0] rel;
        logic [N_SW-1:0]  chg;
        logic [N_BTN:0]   evt;
        logic             irq;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a level flips once D consecutive post-settle samples of the
    // two-cycle-delayed pin all disagree with it; the first D+2 edges after reset copy the pin.
    logic [NI-1:0]  m_d1, m_d2, m_level, m_rise, m_fall;
    logic [N_BTN:0] m_evt;
    logic           m_irq;
    int             m_edges;
    logic [NI-1:0]  m_win[$];

    always @(posedge clk) begin : model
        logic [NI-1:0]  raw, s2;
        logic [N_BTN:0] set_v, clr_v;
        logic           all_diff;
        raw = {btn_i, sw_i};
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            m_evt = '0; m_irq = 1'b0; m_edges = 0;
            m_win.delete();
        end else begin
            s2    = m_d2;
            m_irq = |(m_evt & evt_mask_i);
            set_v = {|(m_rise[N_SW-1:0] | m_fall[N_SW-1:0]), m_rise[NI-1:N_SW]};
            clr_v = evt_clr_i | (int_fin_i ? evt_mask_i : '0);
            m_evt = (m_evt & ~clr_v) | set_v;
            m_rise = '0;
            m_fall = '0;
            if (m_edges < D + 2) begin
                m_level = s2;
                m_edges++;
            end else begin
                m_win.push_back(s2);
                if (m_win.size() > D) void'(m_win.pop_front());
                if (m_win.size() == D) begin
                    for (int b = 0; b < NI; b++) begin
                        all_diff = 1'b1;
                        foreach (m_win[k]) if (m_win[k][b] == m_level[b]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_rise[b]  = s2[b];
                            m_fall[b]  = ~s2[b];
                            m_level[b] = s2[b];
                        end
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
        exp_q.push_back({m_level[N_SW-1:0], m_level[NI-1:N_SW], m_rise[NI-1:N_SW],
                         m_fall[NI-1:N_SW], m_rise[N_SW-1:0] | m_fall[N_SW-1:0], m_evt, m_irq});
    end

    always @(negedge clk) begin : monitor
        snap_t act;
        act = {sw_o, btn_o, btn_press_o, btn_release_o, sw_change_o, evt_o, int_req_o};
        if (exp_q.size() != 0) check("scoreboard", act, exp_q.pop_front());
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N_SW-1:0]  acc_sw;
    logic [N_BTN-1:0] acc_btn;
    logic [N_BTN:0]   acc_evt;
    int               presses, press_at;

    initial begin
        rst = 1'b1; sw_i = 16'hA5A5; btn_i = '0;
        evt_mask_i = 6'h01; evt_clr_i = '0; int_fin_i = 1'b0;
        tick(3);
        check("reset_outputs", {sw_o, btn_o, evt_o, int_req_o}, '0);

        // Settle with switches held: levels load without strobes or events.
        rst = 1'b0;
        acc_sw = '0; acc_evt = '0;
        for (int i = 0; i < D + 2; i++) begin
            tick(1);
            acc_sw |= sw_change_o; acc_evt |= evt_o;
        end
        check("settle_sw_o", sw_o, 16'hA5A5);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            acc_sw |= sw_change_o; acc_evt |= evt_o;
        end
        check("settle_no_change", acc_sw, '0);
        check("settle_no_evt", acc_evt, '0);

        // Clean press: output and strobe exactly D+2 edges after the pin edge.
        btn_i[0] = 1'b1;
        acc_btn = '0;
        for (int i = 0; i < D + 1; i++) begin
            tick(1);
            acc_btn |= btn_o | btn_press_o;
        end
        check("press_not_early", acc_btn, '0);
        tick(1);
        check("press_level", btn_o[0], 1'b1);
        check("press_strobe", btn_press_o[0], 1'b1);
        tick(1);
        check("press_strobe_one_cycle", btn_press_o[0], 1'b0);
        check("press_evt", evt_o, 6'h01);
        tick(1);
        check("press_irq", int_req_o, 1'b1);

        // Short pulse of 10 cycles is rejected.
        btn_i[2] = 1'b1;
        tick(10);
        btn_i[2] = 1'b0;
        acc_btn = '0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            acc_btn |= {btn_o[2], btn_press_o[2], btn_release_o[2]};
        end
        check("glitch_ignored", acc_btn, '0);
        check("glitch_evt", evt_o, 6'h01);

        // Bounce on button 1, ending with a steady press.
        acc_btn = '0;
        for (int k = 0; k < 10; k++) begin
            btn_i[1] = ~btn_i[1];
            for (int i = 0; i < 3; i++) begin
                tick(1);
                acc_btn |= btn_press_o;
            end
        end
        check("bounce_no_press", acc_btn[1], 1'b0);
        btn_i[1] = 1'b1;
        presses = 0; press_at = -1;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            if (btn_press_o[1]) begin
                presses++;
                press_at = n;
            end
        end
        check("bounce_one_press", presses, 1);
        check("bounce_latency", press_at, D + 2);
        check("bounce_evt", evt_o, 6'h03);

        // Clear in the same cycle as a new press strobe: the set wins.
        btn_i[0] = 1'b0;
        tick(25);
        btn_i[0] = 1'b1;
        tick(D + 2);
        check("repress_strobe", btn_press_o[0], 1'b1);
        evt_clr_i = 6'h01;
        tick(1);
        evt_clr_i = '0;
        check("set_wins", evt_o, 6'h03);
        int_fin_i = 1'b1;
        tick(1);
        int_fin_i = 1'b0;
        check("int_fin_masked", evt_o, 6'h02);
        tick(1);
        check("irq_dropped", int_req_o, 1'b0);
        evt_clr_i = 6'h02;
        tick(1);
        evt_clr_i = '0;
        check("clr_bit1", evt_o, '0);

        // Reset in the middle of a switch debounce.
        sw_i = 16'hA5A4;
        tick(8);
        rst = 1'b1;
        tick(1);
        check("midreset_outputs",
              {sw_o, btn_o, btn_press_o, btn_release_o, sw_change_o, evt_o, int_req_o}, '0);
        rst = 1'b0;
        acc_sw = '0; acc_btn = '0; acc_evt = '0;
        for (int i = 0; i < D + 2; i++) begin
            tick(1);
            acc_sw |= sw_change_o; acc_btn |= btn_press_o | btn_release_o;
        end
        check("resettle_sw_o", sw_o, 16'hA5A4);
        check("resettle_btn_o", btn_o, 5'b00011);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            acc_sw |= sw_change_o; acc_btn |= btn_press_o | btn_release_o; acc_evt |= evt_o;
        end
        check("resettle_no_sw_strobe", acc_sw, '0);
        check("resettle_no_btn_strobe", acc_btn, '0);
        check("resettle_no_evt", acc_evt, '0);

        // Random pin activity, clears, interrupt handshakes and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_SW; b++) if ($urandom_range(39) == 0) sw_i[b] = ~sw_i[b];
            for (int b = 0; b < N_BTN; b++) if ($urandom_range(39) == 0) btn_i[b] = ~btn_i[b];
            evt_clr_i = ($urandom_range(15) == 0) ? 6'($urandom) : '0;
            int_fin_i = ($urandom_range(31) == 0);
            if ($urandom_range(63) == 0) evt_mask_i = 6'($urandom);
            rst = ($urandom_range(799) == 0);
            tick(1);
        end
        rst = 1'b0; evt_clr_i = '0; int_fin_i = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
